// File: rtl/branch_predict_unit.sv
// Conditional branch resolve plus a direct-mapped saturating-counter predictor with stats.
// Resolve and predict are combinational; table and counters update on the next edge, no backpressure.
module branch_predict_unit #(
  parameter int PC_WIDTH   = 16,
  parameter int IDX_BITS   = 4,
  parameter int CNT_BITS   = 2,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   fetch_pc,
  output logic                  predict_taken,
  input  logic                  ex_valid,
  input  logic [4:0]            ex_op,
  input  logic [PC_WIDTH-1:0]   ex_pc,
  input  logic                  ex_pred_taken,
  input  logic                  pos_flag,
  input  logic                  neg_flag,
  input  logic                  zero_flag,
  output logic                  is_branch,
  output logic                  branch_taken,
  output logic                  mispredict,
  output logic [STAT_WIDTH-1:0] branch_count,
  output logic [STAT_WIDTH-1:0] mispredict_count
);

  localparam int ENTRIES = 2 ** IDX_BITS;
  localparam logic [CNT_BITS-1:0]   CNT_INIT = {1'b0, {(CNT_BITS-1){1'b1}}};
  localparam logic [CNT_BITS-1:0]   CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0]   CNT_ONE  = 1;
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = 1;

  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_BNEZ = 5'b01101;
  localparam logic [4:0] OP_BLTZ = 5'b01110;
  localparam logic [4:0] OP_BGEZ = 5'b01111;

  logic [CNT_BITS-1:0]   table_q [ENTRIES];
  logic [CNT_BITS-1:0]   entry_d;
  logic [STAT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [STAT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;
  logic [IDX_BITS-1:0]   fetch_idx, ex_idx;

  // Instructions are 2-byte aligned, so bit 0 never contributes to the index.
  assign fetch_idx = fetch_pc[IDX_BITS:1];
  assign ex_idx    = ex_pc[IDX_BITS:1];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[PC_WIDTH-1:IDX_BITS+1], fetch_pc[0],
                            ex_pc[PC_WIDTH-1:IDX_BITS+1], ex_pc[0]};

  assign predict_taken = table_q[fetch_idx][CNT_BITS-1];

  always_comb begin
    is_branch    = 1'b0;
    branch_taken = 1'b0;
    if (ex_valid) begin
      case (ex_op)
        OP_BEQZ: begin is_branch = 1'b1; branch_taken = zero_flag;            end
        OP_BNEZ: begin is_branch = 1'b1; branch_taken = pos_flag | neg_flag;  end
        OP_BLTZ: begin is_branch = 1'b1; branch_taken = neg_flag;             end
        OP_BGEZ: begin is_branch = 1'b1; branch_taken = pos_flag | zero_flag; end
        default: ;
      endcase
    end
  end

  assign mispredict = is_branch && (branch_taken != ex_pred_taken);

  always_comb begin
    entry_d = table_q[ex_idx];
    if (branch_taken) begin
      if (entry_d != CNT_MAX) entry_d = entry_d + CNT_ONE;
    end else begin
      if (entry_d != '0) entry_d = entry_d - CNT_ONE;
    end
  end

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (is_branch && branch_count_q != STAT_MAX)
      branch_count_d = branch_count_q + STAT_ONE;
    if (mispredict && mispredict_count_q != STAT_MAX)
      mispredict_count_d = mispredict_count_q + STAT_ONE;
  end

  // Reset takes priority over a branch resolving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CNT_INIT;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (is_branch) table_q[ex_idx] <= entry_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
